// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl
//   Sequencer and arbiter for the 16x16 register file's single write port,
//   plus the debug read path. After reset it loads SP with SP_INIT, then
//   shares the write port between writeback (priority) and a debug monitor.
//   An anti-starvation counter forces a one-cycle pipeline stall so that
//   debug is always eventually serviced. The register file writes on every
//   falling edge, so cycles with no granted write are steered to IDLE_REG.
//
// Ports:
//   CLK          system clock, rising-edge state updates
//   RSTboot      asynchronous active-low reset
//   wb_we/wb_reg/wb_data           writeback write request
//   dbg_req/dbg_we/dbg_reg/dbg_wdata  debug access request (level, held to ack)
//   rf_dbg_rdata register file read data for dbg_raddr
//   writeReg/writeData  registered write port drive
//   dbg_raddr    debug read address (combinational copy of dbg_reg)
//   dbg_ack      one-cycle completion pulse
//   dbg_rdata    captured debug read data, held until next debug read
//   stall        registered pipeline freeze request
//   init_done    boot init finished
module regfile_port_ctrl #(
  parameter logic [15:0] SP_INIT    = 16'hBF00,
  parameter logic [3:0]  SP_INDEX   = 4'hA,
  parameter logic [3:0]  IDLE_REG   = 4'hF,
  parameter logic [3:0]  STARVE_MAX = 4'd8
) (
  input  logic        CLK,
  input  logic        RSTboot,
  input  logic        wb_we,
  input  logic [3:0]  wb_reg,
  input  logic [15:0] wb_data,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [3:0]  dbg_reg,
  input  logic [15:0] dbg_wdata,
  input  logic [15:0] rf_dbg_rdata,
  output logic [3:0]  writeReg,
  output logic [15:0] writeData,
  output logic [3:0]  dbg_raddr,
  output logic        dbg_ack,
  output logic [15:0] dbg_rdata,
  output logic        stall,
  output logic        init_done
);

  typedef enum logic [1:0] {INIT, RUN, DSTALL} state_t;

  state_t      state_q, state_d;
  logic [3:0]  starve_cnt, starve_cnt_d;
  logic [3:0]  write_reg_d;
  logic [15:0] write_data_d;
  logic        dbg_ack_d;
  logic [15:0] dbg_rdata_d;
  logic        stall_d;
  logic        init_done_d;

  logic dbg_pending;
  logic starve_hit;
  logic dbg_service;

  assign dbg_raddr = dbg_reg;

  // A request still high during its ack cycle is the old one; it only
  // counts as new on the edge after the ack.
  assign dbg_pending = dbg_req & ~dbg_ack;

  // Denied edge that brings the counter to STARVE_MAX-1: WB still wins this
  // edge, but the stall is raised so debug owns the next one.
  assign starve_hit  = (state_q == RUN) & wb_we & dbg_pending &
                       (starve_cnt == STARVE_MAX - 4'd2);

  assign dbg_service = (state_q == DSTALL) |
                       ((state_q == RUN) & ~wb_we & dbg_pending);

  always_ff @(posedge CLK or negedge RSTboot) begin
    if (!RSTboot) begin
      state_q    <= INIT;
      writeReg   <= IDLE_REG;
      writeData  <= '0;
      dbg_ack    <= 1'b0;
      dbg_rdata  <= '0;
      stall      <= 1'b1;
      init_done  <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state_q    <= state_d;
      writeReg   <= write_reg_d;
      writeData  <= write_data_d;
      dbg_ack    <= dbg_ack_d;
      dbg_rdata  <= dbg_rdata_d;
      stall      <= stall_d;
      init_done  <= init_done_d;
      starve_cnt <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    state_d = RUN;
      RUN:     if (starve_hit) state_d = DSTALL;
      DSTALL:  state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    write_reg_d  = writeReg;
    write_data_d = writeData;
    dbg_ack_d    = 1'b0;
    dbg_rdata_d  = dbg_rdata;
    stall_d      = stall;
    init_done_d  = init_done;
    starve_cnt_d = starve_cnt;

    case (state_q)
      INIT: begin
        write_reg_d  = SP_INDEX;
        write_data_d = SP_INIT;
      end
      RUN: begin
        stall_d     = starve_hit;
        init_done_d = 1'b1;
        if (wb_we) begin
          write_reg_d  = wb_reg;
          write_data_d = wb_data;
          if (dbg_pending && starve_cnt != STARVE_MAX - 4'd1)
            starve_cnt_d = starve_cnt + 4'd1;
        end else if (!dbg_pending) begin
          write_reg_d = IDLE_REG;
        end
      end
      DSTALL: begin
        stall_d = 1'b0;
      end
      default: ;
    endcase

    if (dbg_service) begin
      if (dbg_we) begin
        write_reg_d  = dbg_reg;
        write_data_d = dbg_wdata;
      end else begin
        write_reg_d = IDLE_REG;
        dbg_rdata_d = rf_dbg_rdata;
      end
      dbg_ack_d    = 1'b1;
      starve_cnt_d = '0;
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
module tb_regfile_port_ctrl;

  logic        CLK = 1'b0;
  logic        RSTboot;
  logic        wb_we;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic        dbg_req;
  logic        dbg_we;
  logic [3:0]  dbg_reg;
  logic [15:0] dbg_wdata;
  logic [15:0] rf_dbg_rdata;
  logic [3:0]  writeReg;
  logic [15:0] writeData;
  logic [3:0]  dbg_raddr;
  logic        dbg_ack;
  logic [15:0] dbg_rdata;
  logic        stall;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  logic [15:0] rf [16];

  always #5 CLK = ~CLK;

  // Register file model: commits on every falling edge.
  always @(negedge CLK) rf[writeReg] <= writeData;
  assign rf_dbg_rdata = rf[dbg_raddr];

  regfile_port_ctrl #(
    .SP_INIT   (16'hBF00),
    .SP_INDEX  (4'hA),
    .IDLE_REG  (4'hF),
    .STARVE_MAX(4'd8)
  ) dut (
    .CLK         (CLK),
    .RSTboot     (RSTboot),
    .wb_we       (wb_we),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_reg     (dbg_reg),
    .dbg_wdata   (dbg_wdata),
    .rf_dbg_rdata(rf_dbg_rdata),
    .writeReg    (writeReg),
    .writeData   (writeData),
    .dbg_raddr   (dbg_raddr),
    .dbg_ack     (dbg_ack),
    .dbg_rdata   (dbg_rdata),
    .stall       (stall),
    .init_done   (init_done)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RSTboot = 1'b0; wb_we = 0; wb_reg = 0; wb_data = 0;
    dbg_req = 0; dbg_we = 0; dbg_reg = 0; dbg_wdata = 0;
    tick();
    checks++; if (writeReg !== 4'hF) begin errors++; $display("FAIL rst_wreg got %h exp f", writeReg); end
    checks++; if (writeData !== 16'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", writeData); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_stall got %b exp 1", stall); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", init_done); end
    checks++; if (dbg_ack !== 1'b0 || dbg_rdata !== 16'h0) begin errors++; $display("FAIL rst_dbg got ack=%b rd=%h exp 0/0", dbg_ack, dbg_rdata); end
    RSTboot = 1'b1;
    tick();
    checks++; if (writeReg !== 4'hA || writeData !== 16'hBF00) begin errors++; $display("FAIL init_sp got %h/%h exp a/bf00", writeReg, writeData); end
    checks++; if (stall !== 1'b1 || init_done !== 1'b0) begin errors++; $display("FAIL init_flags got st=%b dn=%b exp 1/0", stall, init_done); end
    tick();
    checks++; if (stall !== 1'b0 || init_done !== 1'b1) begin errors++; $display("FAIL run_flags got st=%b dn=%b exp 0/1", stall, init_done); end
    checks++; if (writeReg !== 4'hF || writeData !== 16'hBF00) begin errors++; $display("FAIL run_idle got %h/%h exp f/bf00", writeReg, writeData); end
    checks++; if (rf[4'hA] !== 16'hBF00) begin errors++; $display("FAIL rf_sp got %h exp bf00", rf[4'hA]); end
  endtask

  task automatic test_wb_priority;
    wb_we = 1; wb_reg = 4'h3; wb_data = 16'h1234;
    dbg_req = 1; dbg_we = 1; dbg_reg = 4'h5; dbg_wdata = 16'hAAAA;
    tick();
    checks++; if (writeReg !== 4'h3 || writeData !== 16'h1234 || dbg_ack !== 1'b0) begin errors++; $display("FAIL prio_wb got %h/%h ack=%b exp 3/1234/0", writeReg, writeData, dbg_ack); end
    wb_we = 0;
    tick();
    checks++; if (writeReg !== 4'h5 || writeData !== 16'hAAAA || dbg_ack !== 1'b1) begin errors++; $display("FAIL prio_dbg got %h/%h ack=%b exp 5/aaaa/1", writeReg, writeData, dbg_ack); end
    dbg_req = 0;
    tick();
    checks++; if (dbg_ack !== 1'b0 || writeReg !== 4'hF || stall !== 1'b0) begin errors++; $display("FAIL prio_after got ack=%b wr=%h st=%b exp 0/f/0", dbg_ack, writeReg, stall); end
    checks++; if (rf[3] !== 16'h1234 || rf[5] !== 16'hAAAA) begin errors++; $display("FAIL prio_rf got r3=%h r5=%h exp 1234/aaaa", rf[3], rf[5]); end
  endtask

  task automatic test_starvation;
    wb_we = 1; wb_reg = 4'h6; wb_data = 16'h5555;
    dbg_req = 1; dbg_we = 0; dbg_reg = 4'h3;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++; if (stall !== 1'b0 || dbg_ack !== 1'b0 || writeReg !== 4'h6) begin errors++; $display("FAIL starve_deny%0d got st=%b ack=%b wr=%h exp 0/0/6", i, stall, dbg_ack, writeReg); end
    end
    tick();
    checks++; if (stall !== 1'b1 || dbg_ack !== 1'b0 || writeReg !== 4'h6) begin errors++; $display("FAIL starve_7 got st=%b ack=%b wr=%h exp 1/0/6", stall, dbg_ack, writeReg); end
    tick();
    checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== 16'h1234 || stall !== 1'b0 || writeReg !== 4'hF) begin errors++; $display("FAIL dstall got ack=%b rd=%h st=%b wr=%h exp 1/1234/0/f", dbg_ack, dbg_rdata, stall, writeReg); end
    dbg_req = 0;
    tick();
    checks++; if (writeReg !== 4'h6 || dbg_ack !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL wb_resume got wr=%h ack=%b st=%b exp 6/0/0", writeReg, dbg_ack, stall); end
    wb_we = 0;
    tick();
  endtask

  task automatic test_back_to_back;
    int acks = 0;
    dbg_req = 1; dbg_we = 0; dbg_reg = 4'hA;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dbg_req = 0;
      tick();
      if (dbg_ack) begin
        acks++;
        checks++; if (dbg_rdata !== 16'hBF00) begin errors++; $display("FAIL b2b_rdata%0d got %h exp bf00", i, dbg_rdata); end
      end
      checks++; if (dbg_ack !== ((i % 2) == 0)) begin errors++; $display("FAIL b2b_ack%0d got %b exp %b", i, dbg_ack, (i % 2) == 0); end
    end
    checks++; if (acks != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", acks); end
  endtask

  task automatic test_same_reg;
    wb_we = 1; wb_reg = 4'h5; wb_data = 16'h1111;
    dbg_req = 1; dbg_we = 1; dbg_reg = 4'h5; dbg_wdata = 16'h2222;
    tick();
    wb_we = 0;
    tick();
    checks++; if (dbg_ack !== 1'b1 || writeReg !== 4'h5 || writeData !== 16'h2222) begin errors++; $display("FAIL same_dbg got ack=%b %h/%h exp 1/5/2222", dbg_ack, writeReg, writeData); end
    dbg_req = 0;
    tick();
    checks++; if (rf[5] !== 16'h2222) begin errors++; $display("FAIL same_rf got %h exp 2222", rf[5]); end
  endtask

  task automatic test_reset_in_dstall;
    wb_we = 1; wb_reg = 4'hA; wb_data = 16'h0001;
    dbg_req = 1; dbg_we = 0; dbg_reg = 4'h3;
    for (int i = 0; i < 7; i++) tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pre_rst_stall got %b exp 1", stall); end
    #2;
    RSTboot = 1'b0;
    #1;
    checks++; if (stall !== 1'b1 || dbg_ack !== 1'b0 || writeReg !== 4'hF || init_done !== 1'b0) begin errors++; $display("FAIL midrst got st=%b ack=%b wr=%h dn=%b exp 1/0/f/0", stall, dbg_ack, writeReg, init_done); end
    wb_we = 0;
    dbg_req = 1; dbg_we = 1; dbg_reg = 4'h7; dbg_wdata = 16'h7777;
    tick();
    checks++; if (dbg_ack !== 1'b0 || writeReg !== 4'hF) begin errors++; $display("FAIL held_rst got ack=%b wr=%h exp 0/f", dbg_ack, writeReg); end
    RSTboot = 1'b1;
    tick();
    checks++; if (writeReg !== 4'hA || writeData !== 16'hBF00 || dbg_ack !== 1'b0) begin errors++; $display("FAIL reinit got %h/%h ack=%b exp a/bf00/0", writeReg, writeData, dbg_ack); end
    tick();
    checks++; if (dbg_ack !== 1'b1 || writeReg !== 4'h7 || writeData !== 16'h7777 || init_done !== 1'b1) begin errors++; $display("FAIL pend_svc got ack=%b %h/%h dn=%b exp 1/7/7777/1", dbg_ack, writeReg, writeData, init_done); end
    checks++; if (rf[4'hA] !== 16'hBF00) begin errors++; $display("FAIL reinit_sp got %h exp bf00", rf[4'hA]); end
    dbg_req = 0;
    tick();
    checks++; if (rf[7] !== 16'h7777) begin errors++; $display("FAIL pend_rf got %h exp 7777", rf[7]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;
    test_reset();
    test_wb_priority();
    test_starvation();
    test_back_to_back();
    test_same_reg();
    test_reset_in_dstall();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
